prog_launch_seq: RTL and testbench
==================================

# prog_launch_seq

Run controller that sequences up to NUM_PROGS pre-loaded programs on the processor core over the core's req/ack handshake. It sits between the system/top-level control and the DUT core: on `start` it issues one `req` pulse per selected program, waits for each `ack`, records per-program cycle counts, and reports completion or timeout. This generalises single-program, manually pulsed req/wait(ack) sequencing into a parametrised, watchdog-protected hardware sequencer.

## Interface
- NUM_PROGS, 4, number of program slots; `prog_mask` bit i enables slot i
- CYC_W, 16, width of the per-program cycle counter
- TIMEOUT, 4095, WAIT cycles allowed before abort; must satisfy 1 ≤ TIMEOUT ≤ 2^CYC_W−1
- IDX_W, $clog2(NUM_PROGS) (min 1), derived slot-index width

- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset
- start  in  1  begin a sequence; sampled only in IDLE
- prog_mask  in  NUM_PROGS  slots to run; latched on accepted start
- ack  in  1  core completion for the current program
- req  out  1  one-cycle start pulse to the core
- prog_sel  out  IDX_W  slot index of the program being run; valid while busy
- busy  out  1  high from the cycle after an accepted start until DONE
- done  out  1  one-cycle pulse at end of sequence
- timeout_err  out  1  sticky; set on watchdog abort, cleared on next accepted start
- last_cycles  out  CYC_W  WAIT-cycle count of the most recently acked program
- progs_run  out  IDX_W+1  programs acked in the current/last sequence

## Operation
- States: IDLE, ISSUE, WAIT, NEXT, DONE.
- IDLE: on `start`, latch `prog_mask`, clear `progs_run` and `timeout_err`. If latched mask ≠ 0 → ISSUE with `prog_sel` = lowest set bit. If the mask = 0 → DONE; no req is issued.
- ISSUE: `req`=1 for exactly this cycle; cycle counter cleared; → WAIT. `ack` is ignored in ISSUE.
- WAIT: counter increments each cycle, saturating at 2^CYC_W−1. On `ack`: `last_cycles` ← counter+1 (saturating), `progs_run`++, → NEXT. Otherwise, when counter+1 = TIMEOUT: `timeout_err`←1, remaining slots abandoned, → DONE.
- NEXT: search latched mask for lowest set bit above `prog_sel`. If found → ISSUE with `prog_sel` set to it; otherwise → DONE.
- DONE: `done`=1 for one cycle, `busy`=0 next cycle, → IDLE.
- `start` outside IDLE is ignored. Changes to `prog_mask` after latch have no effect.
- `ack` in IDLE, NEXT or DONE is ignored.

## Timing
- Reset (reset=0 at a rising edge): state IDLE; req, busy, done, timeout_err = 0; prog_sel, last_cycles, progs_run = 0. Reset mid-sequence aborts immediately; there is no done pulse.
- start sampled at edge T → req high during cycle T+1, busy high from T+1.
- Ack-to-next-req latency: ack sampled at edge A (WAIT) → NEXT in cycle A+1 → req in cycle A+2.
- The minimum per-program `last_cycles` is 1 (ack in the first WAIT cycle).
- The last ack → done pulse 2 cycles later. An empty mask → done in cycle T+1 (busy stays high for that single cycle).
- Timeout fires after exactly TIMEOUT WAIT cycles without ack; done is in the following cycle.
- Simultaneous ack and timeout in the same WAIT cycle: ack wins, with no error.

## Configuration
- `PROG_LAUNCH_TIMEOUT_EN` defined: watchdog active as above.
- Not defined: WAIT waits indefinitely for ack; `timeout_err` is tied to 0; the TIMEOUT parameter is unused. The cycle counter still runs and saturates.

## Test plan
- Reset then idle: reset=0 two cycles → all outputs 0; start with mask 4'b0000 → done in the next cycle, req never asserted, progs_run=0.
- Single program: mask 4'b0100, ack 10 cycles after req → one req with prog_sel=2, last_cycles=10, progs_run=1, done 2 cycles after ack, timeout_err=0.
- Multi-program: mask 4'b1011, ack after 3, 5, 7 cycles → req with prog_sel 0, 1, 3 in order, each req 2 cycles after the previous ack; final last_cycles=7, progs_run=3.
- Timeout (macro defined, TIMEOUT=20): mask 4'b0011, no ack → after 20 WAIT cycles timeout_err=1, done pulse, slot 1 never issued, progs_run=0; the next start clears timeout_err.
- Handshake robustness: ack held high during ISSUE and IDLE, start pulsed while busy, prog_mask changed mid-run → stray ack and start ignored, the latched mask is honoured; ack coincident with timeout counts as success.
- Reset mid-WAIT: reset=0 during program 2 of 3 → next cycle all outputs 0 with no done pulse; a fresh start runs normally.

Source files
------------

// File: rtl/prog_launch_seq_if.sv
// Handshake bundle between the launch sequencer (master) and the system/core side (slave).
// The master modport receives start/prog_mask/ack and drives the req pulse plus status.
interface prog_launch_seq_if #(
    parameter  int NUM_PROGS = 4,
    parameter  int CYC_W     = 16,
    localparam int IDX_W     = (NUM_PROGS > 1) ? $clog2(NUM_PROGS) : 1
);
    logic                 start;
    logic [NUM_PROGS-1:0] prog_mask;
    logic                 ack;
    logic                 req;
    logic [IDX_W-1:0]     prog_sel;
    logic                 busy;
    logic                 done;
    logic                 timeout_err;
    logic [CYC_W-1:0]     last_cycles;
    logic [IDX_W:0]       progs_run;

    modport master (
        input  start, prog_mask, ack,
        output req, prog_sel, busy, done, timeout_err, last_cycles, progs_run
    );

    modport slave (
        output start, prog_mask, ack,
        input  req, prog_sel, busy, done, timeout_err, last_cycles, progs_run
    );
endinterface

// File: rtl/prog_launch_seq.sv
// Sequences the masked program slots on the core: one req pulse per slot, waits for ack, counts cycles.
// Latency: start -> req next cycle; ack -> next req (or done) two cycles later; all outputs registered.
// Backpressure: the core paces the run via ack; watchdog abort only with PROG_LAUNCH_TIMEOUT_EN defined.
module prog_launch_seq #(
    parameter  int NUM_PROGS = 4,
    parameter  int CYC_W     = 16,
    parameter  int TIMEOUT   = 4095,
    localparam int IDX_W     = (NUM_PROGS > 1) ? $clog2(NUM_PROGS) : 1
) (
    input  logic              clk,
    input  logic              reset,
    prog_launch_seq_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_NEXT,
        S_DONE
    } state_t;

    state_t               state;
    logic [NUM_PROGS-1:0] mask_q;
    logic [IDX_W-1:0]     sel_q;
    logic [CYC_W-1:0]     cnt;
    logic [CYC_W-1:0]     last_q;
    logic [IDX_W:0]       run_q;
    logic                 req_q;
    logic                 busy_q;
    logic                 done_q;

    logic                 first_vld;
    logic [IDX_W-1:0]     first_idx;
    logic                 next_vld;
    logic [IDX_W-1:0]     next_idx;
    logic [CYC_W:0]       cnt_p1;
    logic [CYC_W-1:0]     cnt_sat_p1;

    // Lowest set bit of the incoming mask, used when a start is accepted.
    always_comb begin
        first_vld = 1'b0;
        first_idx = '0;
        for (int i = NUM_PROGS - 1; i >= 0; i--) begin
            if (bus.prog_mask[i]) begin
                first_vld = 1'b1;
                first_idx = IDX_W'(i);
            end
        end
    end

    // Lowest set bit of the latched mask strictly above the slot just finished.
    always_comb begin
        next_vld = 1'b0;
        next_idx = '0;
        for (int i = NUM_PROGS - 1; i >= 0; i--) begin
            if (mask_q[i] && (IDX_W'(i) > sel_q)) begin
                next_vld = 1'b1;
                next_idx = IDX_W'(i);
            end
        end
    end

    assign cnt_p1     = {1'b0, cnt} + (CYC_W+1)'(1);
    assign cnt_sat_p1 = cnt_p1[CYC_W] ? cnt : cnt_p1[CYC_W-1:0];

`ifdef PROG_LAUNCH_TIMEOUT_EN
    localparam logic [CYC_W:0] TIMEOUT_W = (CYC_W+1)'(TIMEOUT);
    logic terr_q;
    logic wd_hit;

    assign wd_hit = (cnt_p1 == TIMEOUT_W);
`else
    logic unused_timeout;

    assign unused_timeout = (TIMEOUT != 0);
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= S_IDLE;
            mask_q <= '0;
            sel_q  <= '0;
            cnt    <= '0;
            last_q <= '0;
            run_q  <= '0;
            req_q  <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
`ifdef PROG_LAUNCH_TIMEOUT_EN
            terr_q <= 1'b0;
`endif
        end else begin
            req_q  <= 1'b0;
            done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        mask_q <= bus.prog_mask;
                        run_q  <= '0;
                        busy_q <= 1'b1;
`ifdef PROG_LAUNCH_TIMEOUT_EN
                        terr_q <= 1'b0;
`endif
                        if (first_vld) begin
                            sel_q <= first_idx;
                            req_q <= 1'b1;
                            state <= S_ISSUE;
                        end else begin
                            sel_q  <= '0;
                            done_q <= 1'b1;
                            state  <= S_DONE;
                        end
                    end
                end
                S_ISSUE: begin
                    cnt   <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    cnt <= cnt_sat_p1;
                    // An ack arriving in the watchdog's final cycle still counts as success.
                    if (bus.ack) begin
                        last_q <= cnt_sat_p1;
                        run_q  <= run_q + (IDX_W+1)'(1);
                        state  <= S_NEXT;
                    end
`ifdef PROG_LAUNCH_TIMEOUT_EN
                    else if (wd_hit) begin
                        terr_q <= 1'b1;
                        done_q <= 1'b1;
                        state  <= S_DONE;
                    end
`endif
                end
                S_NEXT: begin
                    if (next_vld) begin
                        sel_q <= next_idx;
                        req_q <= 1'b1;
                        state <= S_ISSUE;
                    end else begin
                        done_q <= 1'b1;
                        state  <= S_DONE;
                    end
                end
                S_DONE: begin
                    busy_q <= 1'b0;
                    state  <= S_IDLE;
                end
                default: begin
                    busy_q <= 1'b0;
                    state  <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.req         = req_q;
    assign bus.prog_sel    = sel_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.last_cycles = last_q;
    assign bus.progs_run   = run_q;
`ifdef PROG_LAUNCH_TIMEOUT_EN
    assign bus.timeout_err = terr_q;
`else
    assign bus.timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_prog_launch_seq.sv
// Scoreboard bench for prog_launch_seq: the stimulus side predicts req/done events from slot delays,
// a monitor pops and compares them as the DUT presents req or done.
module tb_prog_launch_seq;
    localparam int NP = 4;
    localparam int CW = 16;
    localparam int TO = 20;
`ifdef PROG_LAUNCH_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    typedef struct {
        int sel;
        int cyc;
    } req_exp_t;

    typedef struct {
        int runs;
        int last;
        int terr;
        int cyc;
    } done_exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic ack_core = 1'b0;
    logic ack_stray = 1'b0;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;
    int   model_last = 0;
    int   plan_d [NP];
    req_exp_t  req_q [$];
    done_exp_t done_q [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    prog_launch_seq_if #(.NUM_PROGS(NP), .CYC_W(CW)) bus ();

    prog_launch_seq #(.NUM_PROGS(NP), .CYC_W(CW), .TIMEOUT(TO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    assign bus.ack = ack_core | ack_stray;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_req"}, bus.req, 0);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_done"}, bus.done, 0);
        chk({tag, "_terr"}, bus.timeout_err, 0);
        chk({tag, "_sel"}, bus.prog_sel, 0);
        chk({tag, "_last"}, bus.last_cycles, 0);
        chk({tag, "_runs"}, bus.progs_run, 0);
    endtask

    task automatic finish_up();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    endtask

    // Reference model: slots in ascending order; a slot acked after d WAIT cycles
    // puts the next req (or done) d+2 cycles after its own req; a silent slot aborts
    // after TO WAIT cycles with done one cycle later.
    task automatic model_push(input int s, input logic [NP-1:0] m, input int rst_cyc);
        int t;
        int runs;
        int d;
        bit tmo;
        req_exp_t  re;
        done_exp_t de;
        t = s + 1;
        runs = 0;
        tmo = 1'b0;
        for (int i = 0; i < NP; i++) begin
            if (m[i]) begin
                if (!tmo) begin
                    d = plan_d[i];
                    if (rst_cyc < 0 || t <= rst_cyc) begin
                        re.sel = i;
                        re.cyc = t;
                        req_q.push_back(re);
                    end
                    if (TO_EN && (d == 0 || d > TO)) begin
                        tmo = 1'b1;
                        t = t + TO + 1;
                    end else begin
                        model_last = d;
                        runs++;
                        t = t + d + 2;
                    end
                end
            end
        end
        if (rst_cyc < 0) begin
            de.runs = runs;
            de.last = model_last;
            de.terr = tmo;
            de.cyc  = t;
            done_q.push_back(de);
        end else begin
            model_last = 0;
        end
    endtask

    task automatic set_plan(input int d0, input int d1, input int d2, input int d3);
        plan_d[0] = d0;
        plan_d[1] = d1;
        plan_d[2] = d2;
        plan_d[3] = d3;
    endtask

    task automatic run_seq(input logic [NP-1:0] m, input bit stray_start, input int rst_off);
        int s;
        int guard;
        @(negedge clk);
        bus.start = 1'b1;
        bus.prog_mask = m;
        s = cyc;
        model_push(s, m, (rst_off >= 0) ? s + rst_off : -1);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        if (rst_off >= 0) begin
            while (cyc < s + rst_off) begin
                @(posedge clk);
                #1;
            end
            reset = 1'b0;
            @(negedge clk);
            @(negedge clk);
            check_zero("midrst");
            @(posedge clk);
            #1;
            reset = 1'b1;
        end else begin
            guard = 0;
            do begin
                @(negedge clk);
                bus.prog_mask = NP'($urandom);
                if (stray_start && bus.busy && $urandom_range(0, 3) == 0) begin
                    bus.start = 1'b1;
                    @(posedge clk);
                    #1;
                    bus.start = 1'b0;
                end
                guard++;
            end while (bus.busy && guard < 500);
            if (guard >= 500) begin
                n_vec++;
                n_err++;
                $display("FAIL busy_bound: busy still %0d after %0d cycles, expected 0", bus.busy, guard);
                finish_up();
            end
        end
        repeat (3) @(negedge clk);
        ack_stray = 1'b1;
        @(negedge clk);
        ack_stray = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    // Core model: acks d WAIT cycles after each req, sometimes with a stray ack during ISSUE.
    initial begin : core
        int d;
        forever begin
            @(negedge clk);
            if (bus.req === 1'b1 && reset) begin
                d = plan_d[bus.prog_sel];
                ack_core = 1'($urandom_range(0, 1));
                @(posedge clk);
                #1;
                ack_core = 1'b0;
                if (d > 0 && reset) begin
                    for (int k = 1; k < d; k++) begin
                        @(posedge clk);
                        #1;
                        if (!reset) break;
                    end
                    if (reset) begin
                        ack_core = 1'b1;
                        @(posedge clk);
                        #1;
                        ack_core = 1'b0;
                    end
                end
            end
        end
    end

    initial begin : monitor
        req_exp_t  re;
        done_exp_t de;
        forever begin
            @(negedge clk);
            if (bus.req === 1'b1) begin
                if (req_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL stray_req: got req with prog_sel %0d at cycle %0d, expected none", bus.prog_sel, cyc);
                end else begin
                    re = req_q.pop_front();
                    chk("req_sel", bus.prog_sel, re.sel);
                    chk("req_cyc", cyc, re.cyc);
                    chk("req_busy", bus.busy, 1);
                end
            end
            if (bus.done === 1'b1) begin
                if (done_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL stray_done: got done at cycle %0d, expected none", cyc);
                end else begin
                    de = done_q.pop_front();
                    chk("done_cyc", cyc, de.cyc);
                    chk("done_runs", bus.progs_run, de.runs);
                    chk("done_last", bus.last_cycles, de.last);
                    chk("done_terr", bus.timeout_err, de.terr);
                    chk("done_busy", bus.busy, 1);
                end
            end
        end
    end

    initial begin : stim
        logic [NP-1:0] m;
        bus.start = 1'b0;
        bus.prog_mask = '0;
        set_plan(1, 1, 1, 1);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_zero("reset");
        @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (2) @(negedge clk);

        run_seq(4'b0000, 1'b0, -1);
        set_plan(1, 1, 10, 1);
        run_seq(4'b0100, 1'b0, -1);
        set_plan(3, 5, 1, 7);
        run_seq(4'b1011, 1'b0, -1);
`ifdef PROG_LAUNCH_TIMEOUT_EN
        set_plan(0, 0, 1, 1);
`else
        set_plan(25, 4, 1, 1);
`endif
        run_seq(4'b0011, 1'b0, -1);
        set_plan(TO, 2, 2, 2);
        run_seq(4'b0001, 1'b1, -1);
        set_plan(3, 30, 3, 1);
        run_seq(4'b0111, 1'b0, 15);
        set_plan(2, 1, 1, 4);
        run_seq(4'b1001, 1'b1, -1);

        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < NP; i++)
                plan_d[i] = TO_EN ? int'($urandom_range(0, 25)) : int'($urandom_range(1, 25));
            m = NP'($urandom_range(0, 15));
            run_seq(m, 1'b1, -1);
        end

        repeat (5) @(negedge clk);
        chk("req_queue_empty", req_q.size(), 0);
        chk("done_queue_empty", done_q.size(), 0);
        finish_up();
    end

endmodule
